// File: rtl/det5_seq_ctrl.sv
// Sequencer for the combinational det5 unit: collects an n x n signed-byte
// matrix (n = 2..5) into an identity-padded 5x5 operand, waits for the det5
// path to settle, then returns det/ovf through a valid/ready result port.
module det5_seq_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int CNT_W      = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   size,
  input  logic         abort,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [199:0] det_matrix,
  input  logic [7:0]   det_in,
  input  logic         det_ovf_in,
  output logic [7:0]   res_det,
  output logic         res_ovf,
  output logic         res_err,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Diagonal element i sits at byte index 6*i counted from the MSB.
  function automatic logic [199:0] identity_op();
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < 5; i++) m[199-48*i -: 8] = 8'h01;
    return m;
  endfunction

  localparam logic [199:0] IDENT = identity_op();

  // Handshakes: an element moves on a clock edge where in_valid && in_ready;
  // a result is consumed on an edge where res_valid && res_ready. Once raised,
  // a valid is held with stable payload until its transfer edge.

  logic [1:0]       state;
  logic [2:0]       n;
  logic [2:0]       row;
  logic [2:0]       col;
  logic [CNT_W-1:0] cnt;
  logic [199:0]     op;

  logic             xfer;
  logic             last_elem;
  logic             size_ok;
  logic [4:0]       elem_num;
  logic [7:0]       elem_msb;

  assign det_matrix = op;
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;

  assign xfer      = in_valid & in_ready;
  assign last_elem = (row == n - 3'd1) && (col == n - 3'd1);
  assign size_ok   = (size >= 3'd2) && (size <= 3'd5);
  assign elem_num  = 5'(row) * 5'd5 + 5'(col);
  assign elem_msb  = 8'd199 - {elem_num, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      n         <= 3'd0;
      row       <= 3'd0;
      col       <= 3'd0;
      cnt       <= '0;
      op        <= IDENT;
      in_ready  <= 1'b0;
      res_det   <= 8'd0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
    end else if (abort) begin
      // Result payload is deliberately kept so the last answer stays readable.
      state     <= S_IDLE;
      row       <= 3'd0;
      col       <= 3'd0;
      cnt       <= '0;
      op        <= IDENT;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (size_ok) begin
              n        <= size;
              op       <= IDENT;
              row      <= 3'd0;
              col      <= 3'd0;
              in_ready <= 1'b1;
              state    <= S_LOAD;
            end else begin
              res_det   <= 8'd0;
              res_ovf   <= 1'b0;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            op[elem_msb -: 8] <= in_data;
            if (last_elem) begin
              in_ready <= 1'b0;
              row      <= 3'd0;
              col      <= 3'd0;
              cnt      <= '0;
              state    <= S_SETTLE;
            end else if (col == n - 3'd1) begin
              col <= 3'd0;
              row <= row + 3'd1;
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        S_SETTLE: begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            res_det   <= det_in;
            res_ovf   <= det_ovf_in;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            cnt       <= '0;
            state     <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
